serial_frame_tx: RTL

SERIAL_FRAME_TX -- requirements
Module: serial_frame_tx

---
 rtl/serial_frame_tx_pkg.sv | 27 ++
 rtl/serial_frame_tx_shift_reg_core.sv | 40 ++++
 rtl/serial_frame_tx.sv | 114 +++++++++++
 3 files changed

// File: rtl/serial_frame_tx_pkg.sv
// Shared definitions for the serial frame transmitter: shift-register modes,
// FSM states and a constant clog2 helper used for counter sizing.
package serial_frame_tx_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } shift_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_GAP   = 2'b10
    } tx_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_frame_tx_shift_reg_core.sv
// Generic WIDTH-bit shift register: hold, shift right, shift left or parallel
// load, with independent serial fill bits for each shift direction.
module shift_reg_core
    import serial_frame_tx_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  shift_mode_e      i_mode,
    input  logic [WIDTH-1:0] i_load_data,
    input  logic             i_fill_msb,
    input  logic             i_fill_lsb,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_next;

    always_comb begin
        w_q_next = r_q;
        unique case (i_mode)
            MODE_SHR:  w_q_next = {i_fill_msb, r_q[WIDTH-1:1]};
            MODE_SHL:  w_q_next = {r_q[WIDTH-2:0], i_fill_lsb};
            MODE_LOAD: w_q_next = i_load_data;
            default:   w_q_next = r_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else begin
            r_q <= w_q_next;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter: accepts a word via valid/ready, emits it
// bit by bit in the captured order, honours stall, then idles GAP cycles.
module serial_frame_tx
    import serial_frame_tx_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             msb_first,
    input  logic             stall,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last
);

    localparam int CNT_W     = clog2(WIDTH);
    localparam int GAP_W_RAW = clog2(GAP + 1);
    // A zero-bit counter is not representable; GAP=0 never enters ST_GAP anyway.
    localparam int GAP_W     = (GAP_W_RAW < 1) ? 1 : GAP_W_RAW;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? (GAP - 1) : 0);

    tx_state_e        r_state;
    tx_state_e        w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [GAP_W-1:0] r_gap_cnt;
    logic             r_msb_first;
    shift_mode_e      w_mode;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_sel_mask;
    logic             w_accept;
    logic             w_shift_en;

    shift_reg_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk         (clk),
        .rst         (rst),
        .i_mode      (w_mode),
        .i_load_data (in_data),
        .i_fill_msb  (1'b0),
        .i_fill_lsb  (1'b0),
        .o_q         (w_q)
    );

    assign w_accept   = (r_state == ST_IDLE) && in_valid;
    assign w_shift_en = (r_state == ST_SHIFT) && !stall;
    // One-hot pick of the output end keeps the whole parallel word in use.
    assign w_sel_mask = r_msb_first ? {1'b1, {(WIDTH-1){1'b0}}}
                                    : {{(WIDTH-1){1'b0}}, 1'b1};

    always_comb begin
        w_state_next = r_state;
        w_mode       = MODE_HOLD;
        in_ready     = 1'b0;
        ser_out      = 1'b0;
        ser_valid    = 1'b0;
        ser_last     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_mode       = MODE_LOAD;
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                ser_out = |(w_q & w_sel_mask);
                if (!stall) begin
                    ser_valid = 1'b1;
                    w_mode    = r_msb_first ? MODE_SHL : MODE_SHR;
                    if (r_cnt == CNT_LAST) begin
                        ser_last     = 1'b1;
                        w_state_next = (GAP > 0) ? ST_GAP : ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_gap_cnt   <= '0;
            r_msb_first <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_cnt       <= '0;
                r_msb_first <= msb_first;
            end else if (w_shift_en) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == ST_GAP) begin
                r_gap_cnt <= r_gap_cnt + 1'b1;
            end else begin
                r_gap_cnt <= '0;
            end
        end
    end

endmodule
